// File: rtl/fifo_wr_arbiter_if.sv
// Two-producer stream bundle plus the FIFO write side, shared by the arbiter and its environment.
// slave = arbiter view, master = producers + FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int DW = 16
);
    logic          req0;
    logic [DW-1:0] din0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] din1;
    logic          ack1;
    logic          fifo_full;
    logic          fifo_wr;
    logic [DW-1:0] fifo_din;
    logic [1:0]    gnt;

    modport slave (
        input  req0, din0, req1, din1, fifo_full,
        output ack0, ack1, fifo_wr, fifo_din, gnt
    );

    modport master (
        output req0, din0, req1, din1, fifo_full,
        input  ack0, ack1, fifo_wr, fifo_din, gnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers, bursts of up to MAX_BURST words.
// Latency: ACK/FIFO_WR are combinational from the registered grant; a new grant from IDLE costs one cycle.
// Backpressure: FIFO_FULL masks ACK combinationally; the grant and burst count freeze while stalled.
module fifo_wr_arbiter #(
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [1:0]    gnt_q;

    logic   cur_ch;
    logic   own_req;
    logic   oth_req;
    state_t oth_state;

    assign cur_ch    = (state_q == G1);
    assign own_req   = cur_ch ? bus.req1 : bus.req0;
    assign oth_req   = cur_ch ? bus.req0 : bus.req1;
    assign oth_state = cur_ch ? G0 : G1;

    // Transfer path is purely combinational off the registered grant.
    assign bus.ack0     = gnt_q[0] & bus.req0 & ~bus.fifo_full;
    assign bus.ack1     = gnt_q[1] & bus.req1 & ~bus.fifo_full;
    assign bus.fifo_wr  = bus.ack0 | bus.ack1;
    assign bus.fifo_din = gnt_q[0] ? bus.din0 :
                          gnt_q[1] ? bus.din1 : '0;
    assign bus.gnt      = gnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // last_q==1 means ch1 was served last, so ch0 wins a tie.
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? G0 : G1;
                end else if (bus.req0) begin
                    state_d = G0;
                end else if (bus.req1) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (!own_req) begin
                    cnt_d   = '0;
                    last_d  = cur_ch;
                    state_d = oth_req ? oth_state : IDLE;
                end else if (!bus.fifo_full) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d  = '0;
                        last_d = cur_ch;
                        if (oth_req) begin
                            state_d = oth_state;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= {state_d == G1, state_d == G0};
        end
    end

    a_ack_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus.ack0 && bus.ack1));
    a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n) !(bus.fifo_wr && bus.fifo_full));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed burst/stall/rotation scenarios plus randomized REQ/FULL traffic,
// checked every cycle against a turn-based reference model and per-producer scoreboards.
module tb_fifo_wr_arbiter;

    localparam int DW = 16;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DW(DW)) bus ();

    fifo_wr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nbad = 0;

    logic tb_rst    = 1'b0;
    logic tb_full   = 1'b0;
    logic full_rand = 1'b0;
    logic clr_req   = 1'b0;

    int          mode  [2] = '{0, 0};
    int          limit [2] = '{1000, 1000};
    int          sent  [2] = '{0, 0};
    logic        pend  [2] = '{1'b0, 1'b0};
    logic        taken [2] = '{1'b0, 1'b0};
    logic [15:0] dat   [2] = '{16'h0, 16'h0};

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] wr_log[$];
    int          wr_ch[$];
    int          wr_cyc[$];
    int          cyc = 0;

    // Reference model: who owns the port, words served in this turn, who was served last.
    int m_own  = 0;
    int m_cnt  = 0;
    int m_last = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Producers and FIFO flag, driven mid-cycle.
    always @(negedge clk) begin
        rst_n = tb_rst;
        bus.fifo_full = full_rand ? ($urandom_range(0, 3) == 0) : tb_full;
        if (clr_req) begin
            for (int c = 0; c < 2; c++) begin
                pend[c]  = 1'b0;
                taken[c] = 1'b0;
                sent[c]  = 0;
                dat[c]   = 16'h0;
            end
            q0.delete();
            q1.delete();
            clr_req = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (taken[c]) begin
                pend[c]  = 1'b0;
                taken[c] = 1'b0;
            end
            if (!pend[c] && sent[c] < limit[c] &&
                (mode[c] == 1 || (mode[c] == 2 && $urandom_range(0, 1) == 1))) begin
                pend[c] = 1'b1;
                dat[c]  = 16'(((c == 0) ? 16'h0100 : 16'h0200) + sent[c]);
                sent[c]++;
                if (c == 0) q0.push_back(dat[c]);
                else        q1.push_back(dat[c]);
            end
        end
        bus.req0 = pend[0];
        bus.din0 = dat[0];
        bus.req1 = pend[1];
        bus.din1 = dat[1];
    end

    // Compare process: every cycle, DUT outputs against the model, then advance the model.
    always @(negedge clk) begin : cmp
        logic        r0, r1, f, e_ack0, e_ack1;
        logic [15:0] e_din, exp_w;
        int          me, other;
        logic        rq_me, rq_oth;
        #2;
        cyc++;
        r0 = bus.req0;
        r1 = bus.req1;
        f  = bus.fifo_full;
        if (!rst_n) begin
            m_own  = 0;
            m_cnt  = 0;
            m_last = 1;
            chk("reset_outputs", {bus.gnt, bus.ack0, bus.ack1, bus.fifo_wr, bus.fifo_din}, 32'h0);
        end else begin
            e_ack0 = (m_own == 1) && r0 && !f;
            e_ack1 = (m_own == 2) && r1 && !f;
            e_din  = (m_own == 1) ? bus.din0 : (m_own == 2) ? bus.din1 : 16'h0;
            chk("gnt", bus.gnt, (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00);
            chk("ack", {bus.ack0, bus.ack1}, {e_ack0, e_ack1});
            chk("fifo_wr", bus.fifo_wr, e_ack0 | e_ack1);
            chk("fifo_din", bus.fifo_din, e_din);
            chk("ack_exclusive", bus.ack0 & bus.ack1, 1'b0);
            chk("no_write_when_full", bus.fifo_wr & f, 1'b0);

            if (bus.fifo_wr) begin
                if (bus.ack1) begin
                    chk("sb_ch1_pending", q1.size() > 0, 1'b1);
                    if (q1.size() > 0) begin
                        exp_w = q1.pop_front();
                        chk("sb_ch1_word", bus.fifo_din, exp_w);
                    end
                end else begin
                    chk("sb_ch0_pending", q0.size() > 0, 1'b1);
                    if (q0.size() > 0) begin
                        exp_w = q0.pop_front();
                        chk("sb_ch0_word", bus.fifo_din, exp_w);
                    end
                end
                wr_log.push_back(bus.fifo_din);
                wr_ch.push_back(bus.ack1 ? 1 : 0);
                wr_cyc.push_back(cyc);
            end
            if (bus.ack0) taken[0] = 1'b1;
            if (bus.ack1) taken[1] = 1'b1;

            if (m_own == 0) begin
                if (r0 && r1)  m_own = (m_last == 1) ? 1 : 2;
                else if (r0)   m_own = 1;
                else if (r1)   m_own = 2;
            end else begin
                me     = m_own - 1;
                other  = 1 - me;
                rq_me  = (me == 1) ? r1 : r0;
                rq_oth = (me == 1) ? r0 : r1;
                if (!rq_me) begin
                    m_cnt  = 0;
                    m_last = me;
                    m_own  = rq_oth ? other + 1 : 0;
                end else if (!f) begin
                    m_cnt++;
                    if (m_cnt == MB) begin
                        m_cnt  = 0;
                        m_last = me;
                        if (rq_oth) m_own = other + 1;
                    end
                end
            end
        end
    end

    task automatic start_test();
        tb_rst    = 1'b0;
        tb_full   = 1'b0;
        full_rand = 1'b0;
        mode      = '{0, 0};
        limit     = '{1000, 1000};
        clr_req   = 1'b1;
        repeat (2) next_cyc();
        wr_log.delete();
        wr_ch.delete();
        wr_cyc.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t2_exp [9];
        logic [15:0] t4_exp [5];
        logic [15:0] t5_exp [6];
        t2_exp = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                   16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0104};
        t4_exp = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200};
        t5_exp = '{16'h0100, 16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204};

        // Reset with both requests held, then both held continuously.
        mode = '{1, 1};
        repeat (3) next_cyc();
        chk("t1_reset_gnt", bus.gnt, 2'b00);
        chk("t1_reset_wr", bus.fifo_wr, 1'b0);
        tb_rst = 1'b1;
        next_cyc();
        chk("t1_idle_no_write", wr_log.size(), 0);
        chk("t1_first_gnt", bus.gnt, 2'b01);
        repeat (12) next_cyc();
        chk("t2_write_every_cycle", wr_log.size(), 12);
        for (int i = 0; i < 9; i++) chk($sformatf("t2_word%0d", i), wr_log[i], t2_exp[i]);

        // Only ch0, 10 words, no bubble at the burst boundary.
        start_test();
        mode[0]  = 1;
        limit[0] = 10;
        tb_rst   = 1'b1;
        repeat (14) next_cyc();
        chk("t3_count", wr_log.size(), 10);
        for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
            chk($sformatf("t3_word%0d", i), wr_log[i], 16'(16'h0100 + i));
            chk($sformatf("t3_ch%0d", i), wr_ch[i], 0);
        end
        if (wr_cyc.size() == 10) chk("t3_contiguous", wr_cyc[9] - wr_cyc[0], 9);

        // Stall under G0 after two words, then finish the burst and rotate.
        start_test();
        mode   = '{1, 1};
        tb_rst = 1'b1;
        repeat (3) next_cyc();
        tb_full = 1'b1;
        repeat (5) next_cyc();
        chk("t4_stalled_count", wr_log.size(), 2);
        chk("t4_stalled_gnt", bus.gnt, 2'b01);
        chk("t4_stalled_wr", bus.fifo_wr, 1'b0);
        tb_full = 1'b0;
        repeat (3) next_cyc();
        chk("t4_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk($sformatf("t4_word%0d", i), wr_log[i], t4_exp[i]);

        // ch0 offers a single word; ch1 takes over for a full burst and keeps the grant.
        start_test();
        mode     = '{1, 1};
        limit[0] = 1;
        tb_rst   = 1'b1;
        repeat (3) next_cyc();
        chk("t5_gnt_switch", bus.gnt, 2'b10);
        repeat (5) next_cyc();
        chk("t5_gnt_kept", bus.gnt, 2'b10);
        chk("t5_count", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++) chk($sformatf("t5_word%0d", i), wr_log[i], t5_exp[i]);

        // Random traffic with a reset in the middle, then drain.
        start_test();
        mode      = '{2, 2};
        full_rand = 1'b1;
        tb_rst    = 1'b1;
        repeat (128) next_cyc();
        tb_rst = 1'b0;
        repeat (2) next_cyc();
        tb_rst = 1'b1;
        repeat (128) next_cyc();
        mode      = '{0, 0};
        full_rand = 1'b0;
        tb_full   = 1'b0;
        for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++) next_cyc();
        chk("t6_ch0_drained", q0.size(), 0);
        chk("t6_ch1_drained", q1.size(), 0);
        chk("t6_activity", wr_log.size() > 40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
